// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the LSU memory initiator: opcodes, funct3 codes,
// FSM state encodings, response error codes and the store lane/byte-enable helpers.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Bundle of the pipeline request, memory port and writeback response signals.
// A request transfers on a clock edge where req_valid & req_ready are both 1; mem_req is held with
// stable address/data until the edge where mem_gnt is 1; rsp_valid is a single-cycle pulse.
interface lsu_mem_initiator_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       ex_mem_instr;
  logic [31:0]       addr;
  logic [31:0]       rs2_val;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_err;

  modport master (
    input  req_valid, ex_mem_instr, addr, rs2_val, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, ex_mem_instr, addr, rs2_val, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half lane from the read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0, lane_h};
      F3_W:    data = rdata;
      default: data = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: accepts one request, drives a req/gnt/rvalid word-addressed memory port,
// and returns an extended load result or an error code as a single-cycle response.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_initiator_if.master bus,
  output logic [1:0]          dbg_state
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        state;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  cnt;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic             is_load;
  logic             is_store;
  logic             f3_ok;
  logic             misaligned;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      load_data;
  logic             unused_bits;

  always_comb begin
    opcode     = bus.ex_mem_instr[6:0];
    f3         = bus.ex_mem_instr[14:12];
    is_load    = (opcode == OP_LOAD);
    is_store   = (opcode == OP_STORE);
    f3_ok      = is_load ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                         : (f3 inside {F3_B, F3_H, F3_W});
    misaligned = ((f3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((f3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    cnt_next   = cnt + 1'b1;
  end

  // Address bits above the word range are dropped so addresses wrap.
  assign unused_bits = ^{bus.ex_mem_instr[31:15], bus.ex_mem_instr[11:7], bus.addr[31:ADDR_W+2]};

  lsu_load_align u_align (
    .rdata   (bus.mem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      f3_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            f3_q   <= f3;
            lo_q   <= bus.addr[1:0];
            we_q   <= is_store;
            data_q <= '0;
            err_q  <= ERR_OK;
            cnt    <= '0;
            if (is_load || is_store) begin
              if (!f3_ok || misaligned) begin
                err_q <= ERR_ALIGN;
                state <= S_RESP;
              end else begin
                addr_q  <= bus.addr[ADDR_W+1:2];
                be_q    <= byte_en(f3[1:0], bus.addr[1:0]);
                wdata_q <= lane_data(f3[1:0], bus.rs2_val);
                state   <= S_REQ;
              end
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) state <= we_q ? S_RESP : S_WAIT_R;
        end
        S_WAIT_R: begin
          // Read data wins over a timeout landing in the same cycle.
          if (bus.mem_rvalid) begin
            data_q <= load_data;
            state  <= S_RESP;
          end else if (cnt_next == CNT_W'(TIMEOUT_CYC)) begin
            err_q <= ERR_TIMEOUT;
            state <= S_RESP;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.mem_req   = (state == S_REQ);
  assign bus.mem_we    = (state == S_REQ) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: a driver plays pipeline and memory, a monitor checks each
// response pulse against an expected queue, and a small table exercises lsu_load_align lanes.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  int         cyc;

  lsu_mem_initiator_if #(.ADDR_W(10)) bus ();

  lsu_mem_initiator #(.ADDR_W(10), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic [31:0] al_rdata;
  logic [1:0]  al_lo;
  logic [2:0]  al_f3;
  logic [31:0] al_data;

  lsu_load_align u_align_tb (
    .rdata   (al_rdata),
    .addr_lo (al_lo),
    .funct3  (al_f3),
    .data    (al_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard: {latency[7:0], err[1:0], data[31:0]}
  logic [41:0] exp_q[$];
  int          acc_q[$];
  bit          prev_rv;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [41:0] e;
    logic [41:0] got;
    int          a0;
    if (rst_n && bus.rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp err=%0b data=%h", bus.rsp_err, bus.rsp_data);
      end else begin
        e   = exp_q.pop_front();
        a0  = acc_q.pop_front();
        got = {8'(cyc - a0), bus.rsp_err, bus.rsp_data};
        if (got !== e) begin
          errors++;
          $display("FAIL rsp got lat=%0d err=%0b data=%h exp lat=%0d err=%0b data=%h",
                   got[41:34], got[33:32], got[31:0], e[41:34], e[33:32], e[31:0]);
        end
      end
      checks++;
      if (prev_rv) begin
        errors++;
        $display("FAIL rsp_pulse got=2-cycle exp=1-cycle");
      end
    end
    prev_rv = rst_n && bus.rsp_valid;
  end

  // driver: pipeline request plus memory-side responder
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] rs2,
                         input bit mem_exp, input logic [9:0] maddr, input logic [3:0] be,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input logic [1:0] err, input logic [31:0] data,
                         input int lat, input bit noise);
    int n;
    bit held;
    bit saw_req;
    bit is_st;
    is_st = (instr[6:0] == OP_STORE);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.ex_mem_instr = instr;
    bus.addr         = a;
    bus.rs2_val      = rs2;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=not-ready exp=ready");
      bus.req_valid = 1'b0;
      return;
    end
    exp_q.push_back({8'(lat), err, data});
    acc_q.push_back(cyc);
    @(negedge clk);
    bus.req_valid = 1'b0;
    saw_req = bus.mem_req;
    if (mem_exp) begin
      held = 1'b1;
      for (int k = 0; k <= gnt_dly; k++) begin
        if (k > 0) @(negedge clk);
        held           = held & bus.mem_req;
        bus.mem_gnt    = (k == gnt_dly);
        bus.mem_rvalid = noise && (k < gnt_dly);
        bus.mem_rdata  = noise ? 32'hBAD0_BAD0 : 32'h0;
      end
      check("mem_req_held", 64'(held), 64'(1));
      check("mem_we", 64'(bus.mem_we), 64'(is_st));
      check("mem_addr", 64'(bus.mem_addr), 64'(maddr));
      check("mem_be", 64'(bus.mem_be), 64'(be));
      check("mem_wdata", 64'(bus.mem_wdata), 64'(wdata));
      @(negedge clk);
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      check("mem_req_drop", 64'(bus.mem_req), 64'(0));
      if (!is_st && rv_dly > 0) begin
        repeat (rv_dly - 1) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      saw_req = saw_req | bus.mem_req;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got=no-rsp exp=rsp");
      exp_q.delete();
      acc_q.delete();
    end
    if (!mem_exp) check("no_mem_req", 64'(saw_req), 64'(0));
  endtask

  logic [31:0] tv_rd [8];
  logic [1:0]  tv_lo [8];
  logic [2:0]  tv_f3 [8];
  logic [31:0] tv_ex [8];

  initial begin
    cyc = 0; checks = 0; errors = 0; prev_rv = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.ex_mem_instr = '0; bus.addr = '0; bus.rs2_val = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    al_rdata = '0; al_lo = '0; al_f3 = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_we", 64'(bus.mem_we), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_mem_be", 64'(bus.mem_be), 64'(0));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst_rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;

    // instr, addr, rs2, mem, maddr, be, wdata, gnt_dly, rv_dly, rdata, err, data, lat, noise
    run_txn(32'h00002023, 32'h10, 32'hDEADBEEF, 1, 10'd4, 4'b1111, 32'hDEADBEEF, 2, 0, 32'h0, 2'b00, 32'h0, 4, 0);
    run_txn(32'h00000023, 32'h13, 32'h000000A5, 1, 10'd4, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0, 2'b00, 32'h0, 2, 0);
    run_txn(32'h00000003, 32'h13, 32'h0, 1, 10'd4, 4'b1000, 32'h0, 0, 1, 32'hA5000000, 2'b00, 32'hFFFFFFA5, 3, 0);
    run_txn(32'h00005003, 32'h22, 32'h0, 1, 10'd8, 4'b1100, 32'h0, 0, 1, 32'h80017FFF, 2'b00, 32'h00008001, 3, 0);
    run_txn(32'h00001003, 32'h22, 32'h0, 1, 10'd8, 4'b1100, 32'h0, 1, 2, 32'h80017FFF, 2'b00, 32'hFFFF8001, 5, 1);
    run_txn(32'h00001023, 32'h2A, 32'h1234BEEF, 1, 10'd10, 4'b1100, 32'hBEEFBEEF, 0, 0, 32'h0, 2'b00, 32'h0, 2, 0);
    run_txn(32'h00004003, 32'h00001005, 32'h0, 1, 10'd1, 4'b0010, 32'h0, 0, 1, 32'h0000F000, 2'b00, 32'h000000F0, 3, 0);
    run_txn(32'h00002003, 32'h06, 32'h0, 0, 10'd0, 4'b0, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 0);
    run_txn(32'h00003003, 32'h20, 32'h0, 0, 10'd0, 4'b0, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 0);
    run_txn(32'h00002023, 32'h12, 32'h55, 0, 10'd0, 4'b0, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 0);
    run_txn(32'h00004023, 32'h20, 32'h55, 0, 10'd0, 4'b0, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 0);
    run_txn(32'h00000013, 32'h20, 32'h55, 0, 10'd0, 4'b0, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0, 1, 0);
    run_txn(32'h00002003, 32'h40, 32'h0, 1, 10'd16, 4'b1111, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 18, 0);

    // abort a load in WAIT_R with reset; no response may follow
    @(negedge clk);
    bus.req_valid = 1'b1; bus.ex_mem_instr = 32'h00002003; bus.addr = 32'h48;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    check("abort_pre_req", 64'(bus.mem_req), 64'(1));
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_state", 64'(dbg_state), 64'(S_WAIT_R));
    check("abort_pre_ready", 64'(bus.req_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", 64'(bus.mem_req), 64'(0));
    check("abort_req_ready", 64'(bus.req_ready), 64'(1));
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    run_txn(32'h00002023, 32'h44, 32'h01020304, 1, 10'd17, 4'b1111, 32'h01020304, 0, 0, 32'h0, 2'b00, 32'h0, 2, 0);
    run_txn(32'h00002003, 32'h44, 32'h0, 1, 10'd17, 4'b1111, 32'h0, 0, 2, 32'h01020304, 2'b00, 32'h01020304, 4, 0);

    // lane-select table on a standalone aligner
    tv_rd[0] = 32'h8899AABB; tv_lo[0] = 2'd0; tv_f3[0] = F3_B;  tv_ex[0] = 32'hFFFFFFBB;
    tv_rd[1] = 32'h8899AABB; tv_lo[1] = 2'd1; tv_f3[1] = F3_BU; tv_ex[1] = 32'h000000AA;
    tv_rd[2] = 32'h8899AABB; tv_lo[2] = 2'd2; tv_f3[2] = F3_B;  tv_ex[2] = 32'hFFFFFF99;
    tv_rd[3] = 32'h8899AABB; tv_lo[3] = 2'd3; tv_f3[3] = F3_BU; tv_ex[3] = 32'h00000088;
    tv_rd[4] = 32'h8899AABB; tv_lo[4] = 2'd0; tv_f3[4] = F3_H;  tv_ex[4] = 32'hFFFFAABB;
    tv_rd[5] = 32'h8899AABB; tv_lo[5] = 2'd2; tv_f3[5] = F3_HU; tv_ex[5] = 32'h00008899;
    tv_rd[6] = 32'h8899AABB; tv_lo[6] = 2'd0; tv_f3[6] = F3_W;  tv_ex[6] = 32'h8899AABB;
    tv_rd[7] = 32'h1234567F; tv_lo[7] = 2'd0; tv_f3[7] = F3_B;  tv_ex[7] = 32'h0000007F;
    for (int i = 0; i < 8; i++) begin
      al_rdata = tv_rd[i]; al_lo = tv_lo[i]; al_f3 = tv_f3[i];
      #1;
      check($sformatf("align_%0d", i), 64'(al_data), 64'(tv_ex[i]));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
